// File: rtl/branch_predictor_f_pkg.sv
// Shared types and opcode constants for the fetch-stage branch predictor.
package branch_predictor_f_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/branch_predictor_f_if.sv
// Fetch/Decode-side signal bundle of the branch predictor.
interface branch_predictor_f_if;
    logic [31:0] iPCF;
    logic [31:0] iInstrF;
    logic        iStallD;
    logic        iFlushD;
    logic        iResolveD;
    logic        iMispredictD;
    logic        oTakeJBF;
    logic [31:0] oTargetF;
    logic        oTakeJBD;

    modport master (
        output iPCF, iInstrF, iStallD, iFlushD, iResolveD, iMispredictD,
        input  oTakeJBF, oTargetF, oTakeJBD
    );

    modport slave (
        input  iPCF, iInstrF, iStallD, iFlushD, iResolveD, iMispredictD,
        output oTakeJBF, oTargetF, oTakeJBD
    );
endinterface

// File: rtl/branch_predictor_f_bht_table.sv
// Table of 2-bit saturating counters: async reset, combinational read, synchronous update.
module bht_table
    import branch_predictor_f_pkg::*;
#(
    parameter int unsigned IDX_W       = 6,
    parameter logic [1:0]  RESET_STATE = 2'b01
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [IDX_W-1:0] rdIdx,
    output logic             rdTaken,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic             wrTaken
);

    ctr_e ctr [2**IDX_W];

    function automatic ctr_e satInc(input ctr_e c);
        return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e satDec(input ctr_e c);
        return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
    endfunction

    // Read is not bypassed: a same-cycle update is seen on the next lookup.
    assign rdTaken = ctr[rdIdx][1];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                ctr[i] <= ctr_e'(RESET_STATE);
            end
        end else if (wrEn) begin
            ctr[wrIdx] <= wrTaken ? satInc(ctr[wrIdx]) : satDec(ctr[wrIdx]);
        end
    end

endmodule

// File: rtl/branch_predictor_f.sv
// Fetch-stage branch predictor: pre-decode, BHT lookup, F->D tracking and training.
// Optional gshare indexing when BHT_GSHARE_EN is defined.
module branch_predictor_f
    import branch_predictor_f_pkg::*;
#(
    parameter int unsigned IDX_W       = 6,
    parameter logic [1:0]  RESET_STATE = 2'b01
) (
    input logic                 iClk,
    input logic                 iRst,
    branch_predictor_f_if.slave bp
);

    logic [6:0]         opcode;
    logic               isBranch;
    logic               isJal;
    logic signed [31:0] immB;
    logic signed [31:0] immJ;
    logic signed [31:0] offset;
    logic               takeF;
    logic               ctrTaken;
    logic [IDX_W-1:0]   lookupIdx;
    logic               validD;
    logic               takeD;
    logic [IDX_W-1:0]   idxD;
    logic               update;
    logic               actual;

    assign opcode   = bp.iInstrF[6:0];
    assign isBranch = (opcode == OPC_BRANCH);
    assign isJal    = (opcode == OPC_JAL);

    assign immB = {{19{bp.iInstrF[31]}}, bp.iInstrF[31], bp.iInstrF[7],
                   bp.iInstrF[30:25], bp.iInstrF[11:8], 1'b0};
    assign immJ = {{11{bp.iInstrF[31]}}, bp.iInstrF[31], bp.iInstrF[19:12],
                   bp.iInstrF[20], bp.iInstrF[30:21], 1'b0};

    always_comb begin
        offset = 32'sd4;
        takeF  = 1'b0;
        if (isBranch) begin
            offset = immB;
            takeF  = ctrTaken;
        end else if (isJal) begin
            offset = immJ;
            takeF  = 1'b1;
        end
    end

    assign bp.oTakeJBF = takeF;
    assign bp.oTargetF = bp.iPCF + $unsigned(offset);

    assign update = bp.iResolveD & validD & ~bp.iStallD;
    assign actual = takeD ^ bp.iMispredictD;

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] history;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            history <= '0;
        end else if (update) begin
            history <= {history[IDX_W-2:0], actual};
        end
    end

    assign lookupIdx = bp.iPCF[IDX_W+1:2] ^ history;
`else
    assign lookupIdx = bp.iPCF[IDX_W+1:2];
`endif

    // F -> D boundary: flush wins over stall.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            validD <= 1'b0;
            takeD  <= 1'b0;
            idxD   <= '0;
        end else if (bp.iFlushD) begin
            validD <= 1'b0;
            takeD  <= 1'b0;
            idxD   <= '0;
        end else if (!bp.iStallD) begin
            validD <= 1'b1;
            takeD  <= takeF;
            idxD   <= lookupIdx;
        end
    end

    assign bp.oTakeJBD = takeD;

    bht_table #(
        .IDX_W       (IDX_W),
        .RESET_STATE (RESET_STATE)
    ) uTable (
        .iClk    (iClk),
        .iRst    (iRst),
        .rdIdx   (lookupIdx),
        .rdTaken (ctrTaken),
        .wrEn    (update),
        .wrIdx   (idxD),
        .wrTaken (actual)
    );

endmodule

// File: tb/tb_branch_predictor_f.sv
// Directed bench for branch_predictor_f (default build, PC-indexed table).
module tb_branch_predictor_f;

    localparam logic [31:0] BEQ8  = 32'h00000463; // beq x0,x0,+8
    localparam logic [31:0] JAL16 = 32'h0100006F; // jal x0,+16
    localparam logic [31:0] BNEM4 = 32'hFE001EE3; // bne x0,x0,-4
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] JALR  = 32'h00008067;

    logic iClk;
    logic iRst;
    int   passCnt;
    int   totalCnt;

    branch_predictor_f_if bp ();

    branch_predictor_f dut (
        .iClk (iClk),
        .iRst (iRst),
        .bp   (bp.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic setF(input logic [31:0] pc, input logic [31:0] instr);
        bp.iPCF    = pc;
        bp.iInstrF = instr;
    endtask

    // Fetch the BEQ at 0x100 into D, then resolve it with the given mispredict flag.
    task automatic trainBr(input logic mis);
        setF(32'h100, BEQ8);
        bp.iResolveD = 1'b0;
        tick();
        setF(32'h180, NOP);
        bp.iResolveD    = 1'b1;
        bp.iMispredictD = mis;
        tick();
        bp.iResolveD    = 1'b0;
        bp.iMispredictD = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        setF(32'h100, BEQ8);
        #1;
        totalCnt++;
        if (bp.oTakeJBD !== 1'b0) $display("FAIL reset_takeD got=%b exp=0", bp.oTakeJBD);
        else passCnt++;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0) $display("FAIL reset_predF got=%b exp=0", bp.oTakeJBF);
        else passCnt++;
        totalCnt++;
        if (bp.oTargetF !== 32'h108) $display("FAIL reset_target got=%h exp=00000108", bp.oTargetF);
        else passCnt++;
        tick();
        tick();
        #2;
        iRst = 1'b0;
        #1;
    endtask

    task automatic test_predict();
        setF(32'h100, BEQ8);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0) $display("FAIL beq_pred got=%b exp=0", bp.oTakeJBF);
        else passCnt++;
        totalCnt++;
        if (bp.oTargetF !== 32'h108) $display("FAIL beq_target got=%h exp=00000108", bp.oTargetF);
        else passCnt++;
        tick();
        setF(32'h104, JAL16);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b1) $display("FAIL jal_pred got=%b exp=1", bp.oTakeJBF);
        else passCnt++;
        totalCnt++;
        if (bp.oTargetF !== 32'h114) $display("FAIL jal_target got=%h exp=00000114", bp.oTargetF);
        else passCnt++;
        tick();
        totalCnt++;
        if (bp.oTakeJBD !== 1'b1) $display("FAIL jal_takeD got=%b exp=1", bp.oTakeJBD);
        else passCnt++;
        setF(32'h200, NOP);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0 || bp.oTargetF !== 32'h204)
            $display("FAIL nop_pred got=%b/%h exp=0/00000204", bp.oTakeJBF, bp.oTargetF);
        else passCnt++;
        tick();
        totalCnt++;
        if (bp.oTakeJBD !== 1'b0) $display("FAIL nop_takeD got=%b exp=0", bp.oTakeJBD);
        else passCnt++;
        setF(32'h300, JALR);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0 || bp.oTargetF !== 32'h304)
            $display("FAIL jalr_pred got=%b/%h exp=0/00000304", bp.oTakeJBF, bp.oTargetF);
        else passCnt++;
        setF(32'h0, BNEM4);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0 || bp.oTargetF !== 32'hFFFFFFFC)
            $display("FAIL bne_wrap got=%b/%h exp=0/fffffffc", bp.oTakeJBF, bp.oTargetF);
        else passCnt++;
        tick();
    endtask

    task automatic test_train();
        trainBr(1'b1);   // 01 -> 10
        setF(32'h100, BEQ8);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b1) $display("FAIL train_up got=%b exp=1", bp.oTakeJBF);
        else passCnt++;
        trainBr(1'b0);   // 10 -> 11
        setF(32'h100, BEQ8);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b1) $display("FAIL train_strong got=%b exp=1", bp.oTakeJBF);
        else passCnt++;
    endtask

    task automatic test_saturate();
        // Counter path from 11: 11,11,11,11,10,01,00,00,01
        logic misVec  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic predVec [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            trainBr(misVec[i]);
            setF(32'h100, BEQ8);
            #1;
            totalCnt++;
            if (bp.oTakeJBF !== predVec[i])
                $display("FAIL saturate_%0d got=%b exp=%b", i, bp.oTakeJBF, predVec[i]);
            else passCnt++;
        end
    endtask

    task automatic test_stall();
        setF(32'h100, BEQ8);
        tick();
        bp.iStallD      = 1'b1;
        bp.iResolveD    = 1'b1;
        bp.iMispredictD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            totalCnt++;
            if (bp.oTakeJBF !== 1'b0 || bp.oTakeJBD !== 1'b0)
                $display("FAIL stall_hold_%0d got=%b/%b exp=0/0", i, bp.oTakeJBF, bp.oTakeJBD);
            else passCnt++;
        end
        bp.iStallD = 1'b0;
        tick();
        bp.iResolveD    = 1'b0;
        bp.iMispredictD = 1'b0;
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b1) $display("FAIL stall_release got=%b exp=1", bp.oTakeJBF);
        else passCnt++;
        trainBr(1'b1);   // 10 -> 01; a double step would have left 11 -> 10
        setF(32'h100, BEQ8);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0) $display("FAIL stall_single_step got=%b exp=0", bp.oTakeJBF);
        else passCnt++;
    endtask

    task automatic test_flush();
        setF(32'h104, JAL16);
        tick();
        totalCnt++;
        if (bp.oTakeJBD !== 1'b1) $display("FAIL flush_pre got=%b exp=1", bp.oTakeJBD);
        else passCnt++;
        setF(32'h180, NOP);
        bp.iStallD = 1'b1;
        tick();
        totalCnt++;
        if (bp.oTakeJBD !== 1'b1) $display("FAIL stall_hold_takeD got=%b exp=1", bp.oTakeJBD);
        else passCnt++;
        setF(32'h104, JAL16);
        bp.iFlushD = 1'b1;
        tick();
        totalCnt++;
        if (bp.oTakeJBD !== 1'b0) $display("FAIL flush_over_stall got=%b exp=0", bp.oTakeJBD);
        else passCnt++;
        bp.iFlushD      = 1'b0;
        bp.iStallD      = 1'b0;
        bp.iResolveD    = 1'b1;
        bp.iMispredictD = 1'b1;
        setF(32'h180, NOP);
        tick();
        bp.iResolveD    = 1'b0;
        bp.iMispredictD = 1'b0;
        setF(32'h100, BEQ8);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0) $display("FAIL flush_no_update got=%b exp=0", bp.oTakeJBF);
        else passCnt++;
    endtask

    task automatic test_collision();
        setF(32'h100, BEQ8);
        tick();
        bp.iResolveD    = 1'b1;
        bp.iMispredictD = 1'b1;
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0) $display("FAIL collision_old got=%b exp=0", bp.oTakeJBF);
        else passCnt++;
        tick();
        bp.iResolveD    = 1'b0;
        bp.iMispredictD = 1'b0;
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b1) $display("FAIL collision_new got=%b exp=1", bp.oTakeJBF);
        else passCnt++;
        totalCnt++;
        if (bp.oTakeJBD !== 1'b0) $display("FAIL collision_captured got=%b exp=0", bp.oTakeJBD);
        else passCnt++;
    endtask

    task automatic test_async_reset();
        trainBr(1'b0);   // 10 -> 11
        setF(32'h100, BEQ8);
        tick();
        totalCnt++;
        if (bp.oTakeJBD !== 1'b1 || bp.oTakeJBF !== 1'b1)
            $display("FAIL areset_pre got=%b/%b exp=1/1", bp.oTakeJBD, bp.oTakeJBF);
        else passCnt++;
        #2;
        iRst = 1'b1;
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b0) $display("FAIL areset_predF got=%b exp=0", bp.oTakeJBF);
        else passCnt++;
        totalCnt++;
        if (bp.oTakeJBD !== 1'b0) $display("FAIL areset_takeD got=%b exp=0", bp.oTakeJBD);
        else passCnt++;
        totalCnt++;
        if (bp.oTargetF !== 32'h108) $display("FAIL areset_target got=%h exp=00000108", bp.oTargetF);
        else passCnt++;
        tick();
        #2;
        iRst = 1'b0;
        #1;
        trainBr(1'b1);   // from 01 this predicts taken; from 00 it would not
        setF(32'h100, BEQ8);
        #1;
        totalCnt++;
        if (bp.oTakeJBF !== 1'b1) $display("FAIL areset_weak_nt got=%b exp=1", bp.oTakeJBF);
        else passCnt++;
    endtask

    initial begin
        passCnt         = 0;
        totalCnt        = 0;
        iRst            = 1'b1;
        bp.iPCF         = 32'h0;
        bp.iInstrF      = NOP;
        bp.iStallD      = 1'b0;
        bp.iFlushD      = 1'b0;
        bp.iResolveD    = 1'b0;
        bp.iMispredictD = 1'b0;
        test_reset();
        test_predict();
        test_train();
        test_saturate();
        test_stall();
        test_flush();
        test_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/branch_predictor_f.md
Name: branch_predictor_f

Overview:
- Fetch-stage branch predictor. It produces the per-instruction taken/not-taken guess that travels with the instruction into Decode, where the decode comparator checks it.
- It consumes the comparator's mispredict result back from Decode to train a table of 2-bit saturating counters.
- It sits beside the PC mux: oTakeJBF/oTargetF steer the next PC, and oTakeJBD feeds the comparator's taken-input.

Parameters:
- IDX_W, 6, BHT index width; table holds 2**IDX_W counters indexed by PC[IDX_W+1:2].
- RESET_STATE, 2'b01, counter value after reset (weakly not-taken).

Ports:
- iClk  input  1  clock
- iRst  input  1  asynchronous active-high reset
- iPCF  input  32  PC of the instruction in Fetch
- iInstrF  input  32  instruction word in Fetch (pre-decoded here)
- iStallD  input  1  Decode stalled; hold F->D pipeline state
- iFlushD  input  1  Decode flushed; kill F->D pipeline state
- iResolveD  input  1  Decode holds a conditional branch (BEQ/BNE) being resolved this cycle
- iMispredictD  input  1  comparator found prediction wrong (its PC-source/flush output, gated to branches)
- oTakeJBF  output  1  redirect fetch to oTargetF (combinational)
- oTargetF  output  32  predicted target, iPCF + immediate (combinational)
- oTakeJBD  output  1  registered prediction of the instruction now in Decode

Behaviour:
- Pre-decode of iInstrF[6:0]:
  - 1100011 = conditional branch. B-imm = sign-extended {i[31], i[7], i[30:25], i[11:8], 0}.
  - 1101111 = JAL. J-imm = sign-extended {i[31], i[19:12], i[20], i[30:21], 0}.
  - Anything else: oTakeJBF=0, oTargetF = iPCF+4.
- Prediction:
  - Branch: oTakeJBF = counter[idx][1].
  - JAL: always predicted taken.
  - JALR: never predicted (Decode resolves it).
- Target arithmetic: 32-bit wrap-around add, no overflow flag.
- F->D pipeline registers: validD, takeD, idxD.
  - iRst: all cleared to 0 asynchronously.
  - iFlushD=1: cleared to 0 next edge. Flush has priority over stall.
  - iStallD=1 (no flush): hold.
  - Otherwise: capture {1, oTakeJBF, idx}.
- oTakeJBD = takeD.
- Update condition: iResolveD & validD & ~iStallD. This guarantees exactly one update per resolved branch even across multi-cycle stalls.
  - actual = takeD ^ iMispredictD.
  - actual=1: counter[idxD] saturating increment, 11 stays 11.
  - actual=0: saturating decrement, 00 stays 00.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Read/write collision (same index looked up in F and updated in the same cycle): F sees the pre-update value; no bypass.
- Reset mid-operation: all counters return to RESET_STATE and all pipeline registers to 0 immediately, without waiting for a clock edge.
- Outputs during reset:
  - oTakeJBD = 0.
  - oTakeJBF/oTargetF stay combinational from iInstrF/iPCF, using reset counter values.
- Latency:
  - Prediction: 0 cycles (combinational from the table).
  - Training: visible to a fetch one cycle after the update edge.

Optional Feature:
- Macro BHT_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register, reset 0.
  - On each update it shifts in the actual outcome (LSB).
  - Lookup index = PC[IDX_W+1:2] ^ history. idxD stores the XORed index, so the update hits the same entry.
- Undefined: no history register; index is PC bits only.

Decomposition:
- Shared control typedef package:
  - 2-bit counter enum (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T).
  - Opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111.
- One sub-module, bht_table: counter array with async reset, one combinational read port, one synchronous saturating-update port. Parameterised by IDX_W and RESET_STATE.

Test Plan:
- Reset, then fetch BEQ at 0x100 (imm +8): oTakeJBF=0, oTargetF=0x108. Next fetch JAL at 0x104 (imm +16): oTakeJBF=1, oTargetF=0x114. Next cycle oTakeJBD=1.
- Training on the BEQ at 0x100 (idx 0x00):
  - Resolve with iMispredictD=1 while predicted NT: counter 01->10.
  - Fetch 0x100 again: oTakeJBF=1.
  - Resolve with iMispredictD=0 while predicted T: counter becomes 11.
- Saturation: four more taken resolves keep the counter at 11. One not-taken resolve (mispredict=1) gives 10, still predicts taken. Two more give 00, then it stays at 00.
- Stall: iResolveD=1 with iStallD=1 for 3 cycles, then released: counter changes by exactly one step, only on the release edge.
- Flush / collision:
  - iFlushD=1 together with iStallD=1: next cycle oTakeJBD=0, and a following iResolveD causes no update.
  - Same-index fetch and update in one cycle: oTakeJBF shows the old value; the next cycle shows the new one.
- Async reset: assert iRst mid-training without a clock edge. The counter read back via oTakeJBF returns to RESET_STATE (predict NT) and oTakeJBD=0 immediately. With BHT_GSHARE_EN, history is also 0.
